eth_tx_arb: RTL and testbench

ETH_TX_ARB -- requirements
Module: eth_tx_arb

---
 rtl/eth_pkg.sv | 17 +
 rtl/eth_tx_arb_if.sv | 31 +++
 rtl/eth_rr_pick.sv | 28 ++
 rtl/eth_tx_arb.sv | 137 +++++++++++++
 tb/tb_eth_tx_arb.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared state type and beat-counter sizing for the TX arbiter
package eth_pkg;

    localparam int BEAT_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    // Counter value seen while the final permitted beat is on the bus.
    function automatic logic [BEAT_CNT_W-1:0] beat_limit(input int max_beats);
        return BEAT_CNT_W'(max_beats - 1);
    endfunction

endpackage

// File: rtl/eth_tx_arb_if.sv
// rtl/eth_tx_arb_if.sv - upstream and MAC-side stream bundle for the TX arbiter
interface eth_tx_arb_if #(
    parameter int N_PORTS    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
    logic [N_PORTS-1:0]            s_axis_tvalid;
    logic [N_PORTS-1:0]            s_axis_tlast;
    logic [N_PORTS-1:0]            s_axis_tuser;
    logic [N_PORTS-1:0]            s_axis_tready;
    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic                          m_axis_tvalid;
    logic                          m_axis_tlast;
    logic                          m_axis_tuser;
    logic                          m_axis_tready;

    // master: the arbiter; slave: the requesters and MAC around it
    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        input  m_axis_tready
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        output m_axis_tready
    );
endinterface

// File: rtl/eth_rr_pick.sv
// rtl/eth_rr_pick.sv - round-robin first-requester search starting after last_i
module eth_rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand;

    // Walk from the farthest candidate back to last_i+1 so the nearest hit wins.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last_i) + k) % N);
            if (req_i[cand]) begin
                idx_o = cand;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arb.sv
// rtl/eth_tx_arb.sv - frame-granular round-robin arbiter feeding one MAC TX stream
module eth_tx_arb
    import eth_pkg::*;
#(
    parameter  int N_PORTS    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BEATS  = 1522,
    localparam int PW         = $clog2(N_PORTS)
) (
    input  logic          tx_clk,
    input  logic          tx_rst_n,
    eth_tx_arb_if.master  axis,
    input  logic          cfg_enable,
    output logic          grant_valid,
    output logic [PW-1:0] grant_port,
    output logic          stat_trunc,
    output logic          stat_drop_beat
);

    arb_state_e            state_q, state_d;
    logic [PW-1:0]         grant_q, grant_d;
    logic [PW-1:0]         last_q, last_d;
    logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  trunc_q, trunc_d;
    logic                  drop_q, drop_d;

    logic [DATA_WIDTH-1:0] port_data [N_PORTS];
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_valid, src_last, src_user, at_limit;
    logic [PW-1:0]         pick_idx;
    logic                  pick_any;

    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid, m_last, m_user;
    logic [N_PORTS-1:0]    s_ready;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        assign port_data[i] = axis.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign src_data  = port_data[grant_q];
    assign src_valid = axis.s_axis_tvalid[grant_q];
    assign src_last  = axis.s_axis_tlast[grant_q];
    assign src_user  = axis.s_axis_tuser[grant_q];
    assign at_limit  = (cnt_q == beat_limit(MAX_BEATS));

    eth_rr_pick #(.N(N_PORTS)) u_pick (
        .req_i  (axis.s_axis_tvalid),
        .last_i (last_q),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        trunc_d = 1'b0;
        drop_d  = 1'b0;
        m_data  = '0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_user  = 1'b0;
        s_ready = '0;
        case (state_q)
            IDLE: begin
                if (cfg_enable && pick_any) begin
                    grant_d = pick_idx;
                    state_d = PASS;
                end
            end
            PASS: begin
                // A frame reaching the limit without tlast is cut here and flagged bad.
                m_data  = src_data;
                m_valid = src_valid;
                m_last  = src_last | at_limit;
                m_user  = src_user | (at_limit & ~src_last);
                s_ready[grant_q] = axis.m_axis_tready;
                if (src_valid && axis.m_axis_tready) begin
                    if (src_last) begin
                        cnt_d   = '0;
                        last_d  = grant_q;
                        state_d = IDLE;
                    end else if (at_limit) begin
                        cnt_d   = '0;
                        trunc_d = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                s_ready[grant_q] = 1'b1;
                if (src_valid) begin
                    drop_d = 1'b1;
                    if (src_last) begin
                        last_d  = grant_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= PW'(N_PORTS - 1);
            cnt_q   <= '0;
            trunc_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
            drop_q  <= drop_d;
        end
    end

    assign axis.m_axis_tdata  = m_data;
    assign axis.m_axis_tvalid = m_valid;
    assign axis.m_axis_tlast  = m_last;
    assign axis.m_axis_tuser  = m_user;
    assign axis.s_axis_tready = s_ready;

    assign grant_valid    = (state_q != IDLE);
    assign grant_port     = grant_q;
    assign stat_trunc     = trunc_q;
    assign stat_drop_beat = drop_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// tb/tb_eth_tx_arb.sv - scoreboard bench for eth_tx_arb with a frame-level round-robin model
module tb_eth_tx_arb;

    localparam int NP   = 4;
    localparam int DW   = 8;
    localparam int MAXB = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_enable;
    logic       grant_valid;
    logic [1:0] grant_port;
    logic       stat_trunc;
    logic       stat_drop_beat;

    eth_tx_arb_if #(.N_PORTS(NP), .DATA_WIDTH(DW)) axis ();

    eth_tx_arb #(.N_PORTS(NP), .DATA_WIDTH(DW), .MAX_BEATS(MAXB)) dut (
        .tx_clk         (clk),
        .tx_rst_n       (rst_n),
        .axis           (axis),
        .cfg_enable     (cfg_enable),
        .grant_valid    (grant_valid),
        .grant_port     (grant_port),
        .stat_trunc     (stat_trunc),
        .stat_drop_beat (stat_drop_beat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
        logic [1:0]    port;
    } exp_t;

    beat_t src_q [NP][$];
    beat_t mdl_q [NP][$];
    exp_t  exp_q [$];
    int    frame_ports [$];
    bit    in_frame [NP];

    int checks = 0, errors = 0;
    int mdl_last = NP - 1;
    int exp_trunc = 0, exp_drop = 0, seen_trunc = 0, seen_drop = 0;
    int hs_cnt = 0, cyc = 0, first_hs = -1, last_hs = -1;
    bit gap_en = 1'b0;
    int rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit src_busy();
        for (int p = 0; p < NP; p++)
            if (src_q[p].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic add_frame(input int p, input int len, input bit usr);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = DW'($urandom);
            b.last = (i == len - 1);
            b.user = usr && (i == len - 1);
            src_q[p].push_back(b);
            mdl_q[p].push_back(b);
        end
    endtask

    // Whole frames leave in round-robin order; beats past MAXB are swallowed.
    task automatic build_expected();
        int    p, n;
        beat_t b;
        exp_t  e;
        forever begin
            p = -1;
            for (int k = 1; k <= NP; k++)
                if (p < 0 && mdl_q[(mdl_last + k) % NP].size() != 0) p = (mdl_last + k) % NP;
            if (p < 0) break;
            n = 0;
            do begin
                b = mdl_q[p].pop_front();
                n++;
                e.data = b.data;
                e.port = 2'(p);
                if (n < MAXB) begin
                    e.last = b.last;
                    e.user = b.user;
                    exp_q.push_back(e);
                end else if (n == MAXB) begin
                    e.last = 1'b1;
                    e.user = b.last ? b.user : 1'b1;
                    exp_q.push_back(e);
                    if (!b.last) exp_trunc++;
                end else begin
                    exp_drop++;
                end
            end while (!b.last);
            mdl_last = p;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_busy()) && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_drained"}, 64'(exp_q.size()), 64'(0));
        chk({name, "_src_idle"}, 64'(src_busy()), 64'(0));
        chk({name, "_trunc"}, 64'(seen_trunc), 64'(exp_trunc));
        chk({name, "_drop"}, 64'(seen_drop), 64'(exp_drop));
    endtask

    task automatic wait_hs(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (hs_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_reached"}, 64'(hs_cnt >= target), 64'(1));
    endtask

    initial begin : driver
        bit take [NP];
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) take[p] = axis.s_axis_tvalid[p] && axis.s_axis_tready[p];
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (take[p] && src_q[p].size() != 0) begin
                    in_frame[p] = !src_q[p][0].last;
                    void'(src_q[p].pop_front());
                end
                if (src_q[p].size() != 0) begin
                    axis.s_axis_tvalid[p] = !(gap_en && in_frame[p] && $urandom_range(0, 3) == 0);
                    axis.s_axis_tdata[p*DW +: DW] = src_q[p][0].data;
                    axis.s_axis_tlast[p] = src_q[p][0].last;
                    axis.s_axis_tuser[p] = src_q[p][0].user;
                end else begin
                    axis.s_axis_tvalid[p] = 1'b0;
                    axis.s_axis_tdata[p*DW +: DW] = '0;
                    axis.s_axis_tlast[p] = 1'b0;
                    axis.s_axis_tuser[p] = 1'b0;
                end
            end
            case (rdy_mode)
                0:       axis.m_axis_tready = 1'b1;
                1:       axis.m_axis_tready = ~axis.m_axis_tready;
                default: axis.m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        exp_t          e;
        logic [NP-1:0] want;
        forever begin
            @(negedge clk);
            if (stat_trunc) seen_trunc++;
            if (stat_drop_beat) seen_drop++;
            if (axis.m_axis_tvalid) begin
                want = '0;
                want[grant_port] = axis.m_axis_tready;
                chk("tready_mirror", 64'(axis.s_axis_tready), 64'(want));
            end
            if (axis.m_axis_tvalid && axis.m_axis_tready) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                if (axis.m_axis_tlast) frame_ports.push_back(int'(grant_port));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got data %0d port %0d expected no beat", axis.m_axis_tdata, grant_port);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(axis.m_axis_tdata), 64'(e.data));
                    chk("beat_last", 64'(axis.m_axis_tlast), 64'(e.last));
                    chk("beat_user", 64'(axis.m_axis_tuser), 64'(e.user));
                    chk("beat_port", 64'(grant_port), 64'(e.port));
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int h0, t0, d0, nf, n;
        axis.s_axis_tdata  = '0;
        axis.s_axis_tvalid = '0;
        axis.s_axis_tlast  = '0;
        axis.s_axis_tuser  = '0;
        axis.m_axis_tready = 1'b0;
        rst_n      = 1'b0;
        cfg_enable = 1'b1;

        // Two 64-beat frames from ports 0 and 2, exactly at the beat limit.
        add_frame(0, 64, 1'b0);
        add_frame(2, 64, 1'b0);
        build_expected();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_m_side", 64'({axis.m_axis_tvalid, axis.m_axis_tlast, axis.m_axis_tuser, axis.m_axis_tdata}), 64'(0));
        chk("rst_s_tready", 64'(axis.s_axis_tready), 64'(0));
        chk("rst_grant", 64'({grant_valid, grant_port}), 64'(0));
        chk("rst_stats", 64'({stat_trunc, stat_drop_beat}), 64'(0));
        h0 = hs_cnt;
        first_hs = -1;
        frame_ports.delete();
        rst_n = 1'b1;
        wait_done("two_frames", 2000);
        chk("two_frames_beats", 64'(hs_cnt - h0), 64'(128));
        chk("two_frames_span", 64'(last_hs - first_hs), 64'(128));
        chk("two_frames_first", 64'(frame_ports.size() > 0 ? frame_ports[0] : -1), 64'(0));

        // 8-beat frame on port 3 under a toggling MAC ready.
        rdy_mode = 1;
        h0 = hs_cnt;
        add_frame(3, 8, 1'b0);
        build_expected();
        wait_done("toggle", 500);
        chk("toggle_hs", 64'(hs_cnt - h0), 64'(8));
        rdy_mode = 0;

        // All ports busy with three frames each.
        frame_ports.delete();
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < NP; p++) add_frame(p, $urandom_range(2, 12), 1'($urandom_range(0, 1)));
        build_expected();
        wait_done("rr", 2000);
        chk("rr_frames", 64'(frame_ports.size()), 64'(12));
        for (int i = 0; i < frame_ports.size(); i++) chk("rr_order", 64'(frame_ports[i]), 64'(i % NP));

        // Over-length frame on port 1: MAXB beats out, the rest dropped.
        t0 = seen_trunc;
        d0 = seen_drop;
        add_frame(1, MAXB + 4, 1'b0);
        build_expected();
        wait_done("trunc", 1000);
        chk("trunc_pulses", 64'(seen_trunc - t0), 64'(1));
        chk("trunc_drops", 64'(seen_drop - d0), 64'(4));

        // Enable dropped mid-frame on port 3 while port 0 waits.
        h0 = hs_cnt;
        add_frame(3, 10, 1'b0);
        build_expected();
        wait_hs("cfg_beat5", h0 + 5, 200);
        #1;
        cfg_enable = 1'b0;
        add_frame(0, 6, 1'b0);
        build_expected();
        n = 0;
        while (exp_q.size() > 6 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (8) @(posedge clk);
        #1;
        chk("cfg_p3_beats", 64'(hs_cnt - h0), 64'(10));
        chk("cfg_no_grant", 64'(grant_valid), 64'(0));
        chk("cfg_p0_pending", 64'(exp_q.size()), 64'(6));
        cfg_enable = 1'b1;
        wait_done("cfg", 500);

        // Randomized frames with mid-frame gaps and random MAC backpressure.
        gap_en   = 1'b1;
        rdy_mode = 2;
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < NP; p++) begin
                nf = $urandom_range(0, 2);
                for (int f = 0; f < nf; f++) add_frame(p, $urandom_range(1, 70), 1'($urandom_range(0, 1)));
            end
            build_expected();
            wait_done("random", 8000);
        end
        gap_en   = 1'b0;
        rdy_mode = 0;

        // Reset in the middle of a port 2 frame.
        h0 = hs_cnt;
        add_frame(2, 10, 1'b0);
        build_expected();
        wait_hs("rst_beat3", h0 + 3, 200);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_side", 64'({axis.m_axis_tvalid, axis.m_axis_tlast, axis.m_axis_tuser, axis.m_axis_tdata}), 64'(0));
        chk("midrst_s_tready", 64'(axis.s_axis_tready), 64'(0));
        chk("midrst_grant", 64'({grant_valid, grant_port}), 64'(0));
        repeat (2) @(posedge clk);
        #3;
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            mdl_q[p].delete();
            in_frame[p] = 1'b0;
        end
        exp_q.delete();
        mdl_last   = NP - 1;
        exp_trunc  = 0;
        exp_drop   = 0;
        seen_trunc = 0;
        seen_drop  = 0;
        frame_ports.delete();
        add_frame(2, 5, 1'b0);
        add_frame(0, 5, 1'b0);
        build_expected();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_done("post_rst", 500);
        chk("post_rst_first", 64'(frame_ports.size() > 0 ? frame_ports[0] : -1), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
